// File: rtl/eq_sdp_pipe.sv
// eq_sdp_pipe
// Three-stage add/subtract datapath computing n = (a +/- b) +/- c with
// elastic valid/ready handshaking on both sides and optional unsigned
// saturation at each arithmetic stage.
//
// Parameters:
//   WIDTH    operand/result width (>= 2)
//   SEL_MODE 0: stage-1 op chosen by ctl_1; 1: chosen by a[0] (odd -> add)
//   SAT      0: modular arithmetic; 1: unsigned saturating arithmetic
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   input beat offered
//   in_ready   block can accept a beat this cycle
//   ctl_1      stage-1 op select (1 = add), used when SEL_MODE = 0
//   ctl_2      stage-2 op select (1 = add, 0 = subtract)
//   a, b, c    unsigned operands
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   out        result n
//   out_ovf    carry or borrow occurred in either stage for this beat
module eq_sdp_pipe #(
  parameter int WIDTH    = 8,
  parameter int SEL_MODE = 0,
  parameter int SAT      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ctl_1,
  input  logic             ctl_2,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_ovf
);

  // One arithmetic stage: returns {flag, result}. The flag is the carry on
  // add or the borrow on subtract; both fall out of bit WIDTH of a
  // WIDTH+1-bit operation on zero-extended operands. With saturation the
  // result clamps to all-ones (carry) or zero (borrow).
  function automatic logic [WIDTH:0] arith(input logic             add,
                                           input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    if (add) begin
      wide = {1'b0, x} + {1'b0, y};
      res  = (SAT != 0 && wide[WIDTH]) ? {WIDTH{1'b1}} : wide[WIDTH-1:0];
    end else begin
      wide = {1'b0, x} - {1'b0, y};
      res  = (SAT != 0 && wide[WIDTH]) ? {WIDTH{1'b0}} : wide[WIDTH-1:0];
    end
    return {wide[WIDTH], res};
  endfunction

  // Stage valid bits
  logic v1_reg, v2_reg, v3_reg;
  logic v1_next, v2_next, v3_next;

  // S1: registered inputs
  logic             s1_ctl_1_reg, s1_ctl_2_reg;
  logic [WIDTH-1:0] s1_a_reg, s1_b_reg, s1_c_reg;

  // S2: stage-1 result plus operands still needed downstream
  logic [WIDTH-1:0] s2_m_reg, s2_c_reg;
  logic             s2_ctl_2_reg, s2_ovf1_reg;

  // S3: final result
  logic [WIDTH-1:0] s3_n_reg;
  logic             s3_ovf_reg;

  // Handshake terms, evaluated from the output end backwards so a full
  // pipe can still move when the sink drains it.
  logic adv3, ld3, ld2, ld1;

  assign adv3     = v3_reg & out_ready;
  assign ld3      = v2_reg & (~v3_reg | adv3);
  assign ld2      = v1_reg & (~v2_reg | ld3);
  assign in_ready = ~v1_reg | ld2;
  assign ld1      = in_valid & in_ready;

  // Stage-1 arithmetic on the S1 register contents
  logic             sel_1;
  logic [WIDTH:0]   st1_res;
  logic [WIDTH:0]   st2_res;

  assign sel_1   = (SEL_MODE != 0) ? s1_a_reg[0] : s1_ctl_1_reg;
  assign st1_res = arith(sel_1, s1_a_reg, s1_b_reg);
  assign st2_res = arith(s2_ctl_2_reg, s2_m_reg, s2_c_reg);

  // A stage's valid bit sets when it loads and clears when its contents
  // move on without being replaced.
  always_comb begin
    v1_next = v1_reg;
    v2_next = v2_reg;
    v3_next = v3_reg;
    if (ld1) begin
      v1_next = 1'b1;
    end else if (ld2) begin
      v1_next = 1'b0;
    end
    if (ld2) begin
      v2_next = 1'b1;
    end else if (ld3) begin
      v2_next = 1'b0;
    end
    if (ld3) begin
      v3_next = 1'b1;
    end else if (adv3) begin
      v3_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      v3_reg       <= 1'b0;
      s1_ctl_1_reg <= 1'b0;
      s1_ctl_2_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_c_reg     <= '0;
      s2_m_reg     <= '0;
      s2_c_reg     <= '0;
      s2_ctl_2_reg <= 1'b0;
      s2_ovf1_reg  <= 1'b0;
      s3_n_reg     <= '0;
      s3_ovf_reg   <= 1'b0;
    end else begin
      v1_reg <= v1_next;
      v2_reg <= v2_next;
      v3_reg <= v3_next;
      if (ld1) begin
        s1_ctl_1_reg <= ctl_1;
        s1_ctl_2_reg <= ctl_2;
        s1_a_reg     <= a;
        s1_b_reg     <= b;
        s1_c_reg     <= c;
      end
      if (ld2) begin
        s2_m_reg     <= st1_res[WIDTH-1:0];
        s2_ovf1_reg  <= st1_res[WIDTH];
        s2_ctl_2_reg <= s1_ctl_2_reg;
        s2_c_reg     <= s1_c_reg;
      end
      if (ld3) begin
        s3_n_reg   <= st2_res[WIDTH-1:0];
        s3_ovf_reg <= s2_ovf1_reg | st2_res[WIDTH];
      end
    end
  end

  assign out_valid = v3_reg;
  assign out       = s3_n_reg;
  assign out_ovf   = s3_ovf_reg;

endmodule

// File: tb/tb_eq_sdp_pipe.sv
// Testbench for eq_sdp_pipe. Four instances share one stimulus stream:
// instance i has SAT = i%2 and SEL_MODE = i/2, so all parameter
// combinations are exercised with identical flow control.
module tb_eq_sdp_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       ctl_1, ctl_2;
  logic [7:0] a, b, c;
  logic       out_ready;

  logic       in_ready_w  [4];
  logic       out_valid_w [4];
  logic [7:0] out_w       [4];
  logic       ovf_w       [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    eq_sdp_pipe #(
      .WIDTH   (8),
      .SEL_MODE(gi / 2),
      .SAT     (gi % 2)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready_w[gi]),
      .ctl_1    (ctl_1),
      .ctl_2    (ctl_2),
      .a        (a),
      .b        (b),
      .c        (c),
      .out_valid(out_valid_w[gi]),
      .out_ready(out_ready),
      .out      (out_w[gi]),
      .out_ovf  (ovf_w[gi])
    );
  end

  typedef struct {
    logic [7:0]      a, b, c;
    logic            c1, c2;
    logic [3:0][8:0] exp;   // {ovf, out} per instance
  } vec_t;

  typedef struct {
    logic [3:0][8:0] exp;
    int              acc_cyc;
    bit              lat_chk;
  } sb_t;

  vec_t tab [8];
  sb_t  sb_q [$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pop_cnt, first_pop, last_pop;
  bit last_acc;
  bit drive_tab, drive_lat;
  logic [3:0][8:0] drive_exp;

  task automatic chk(input string name, input int inst,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0d expected=%0d", name, inst, cyc, got, exp);
    end
  endtask

  // Independent reference: plain integer arithmetic, wrap or clamp by hand.
  function automatic logic [8:0] model(input logic [7:0] ma, mb, mc,
                                       input logic mc1, mc2,
                                       input int sel_mode, input int sat);
    int t, m, n;
    bit o1, o2, s;
    s = (sel_mode != 0) ? ma[0] : mc1;
    if (s) begin
      t = int'(ma) + int'(mb); o1 = (t > 255); m = o1 ? (sat != 0 ? 255 : t - 256) : t;
    end else begin
      t = int'(ma) - int'(mb); o1 = (t < 0);   m = o1 ? (sat != 0 ? 0 : t + 256) : t;
    end
    if (mc2) begin
      t = m + int'(mc); o2 = (t > 255); n = o2 ? (sat != 0 ? 255 : t - 256) : t;
    end else begin
      t = m - int'(mc); o2 = (t < 0);   n = o2 ? (sat != 0 ? 0 : t + 256) : t;
    end
    model = {o1 | o2, n[7:0]};
  endfunction

  function automatic vec_t mkv(input int va, vb, vc, input bit v1, v2,
                               input bit o0, input int n0, input bit o1, input int n1,
                               input bit o2, input int n2, input bit o3, input int n3);
    vec_t v;
    v.a = va[7:0]; v.b = vb[7:0]; v.c = vc[7:0]; v.c1 = v1; v.c2 = v2;
    v.exp[0] = {o0, n0[7:0]};
    v.exp[1] = {o1, n1[7:0]};
    v.exp[2] = {o2, n2[7:0]};
    v.exp[3] = {o3, n3[7:0]};
    return v;
  endfunction

  // One clock cycle: observe at mid-low phase, pop on output handshake,
  // push on input handshake, then advance to the next falling edge.
  task automatic step();
    sb_t e;
    #1;
    last_acc = 1'b0;
    if (reset) begin
      if (out_valid_w[0] && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 0, 32'(out_w[0]), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          for (int i = 0; i < 4; i++) begin
            chk("result", i, {23'd0, ovf_w[i], out_w[i]}, {23'd0, e.exp[i]});
            if (i > 0) chk("valid_align", i, 32'(out_valid_w[i]), 32'd1);
          end
          if (e.lat_chk) chk("latency", 0, cyc - e.acc_cyc, 3);
          if (pop_cnt == 0) first_pop = cyc;
          last_pop = cyc;
          pop_cnt++;
        end
      end
      if (in_valid && in_ready_w[0]) begin
        last_acc  = 1'b1;
        e.acc_cyc = cyc;
        e.lat_chk = drive_lat;
        for (int i = 0; i < 4; i++)
          e.exp[i] = drive_tab ? drive_exp[i] : model(a, b, c, ctl_1, ctl_2, i / 2, i % 2);
        sb_q.push_back(e);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic begin_window();
    pop_cnt = 0; first_pop = 0; last_pop = 0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) step();
    chk("drain_left", 0, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    int na;
    tab[0] = mkv( 10,   3,   5, 1, 0, 0,   8, 0,   8, 0,   2, 0,   2);
    tab[1] = mkv(200, 100,   0, 1, 1, 1,  44, 1, 255, 0, 100, 0, 100);
    tab[2] = mkv(  5,   2,   0, 0, 0, 0,   3, 0,   3, 0,   7, 0,   7);
    tab[3] = mkv(  4,   6,   0, 0, 0, 1, 254, 1,   0, 1, 254, 1,   0);
    tab[4] = mkv(  0,   0,   1, 1, 0, 1, 255, 1,   0, 1, 255, 1,   0);
    tab[5] = mkv(255,   1, 255, 1, 1, 1, 255, 1, 255, 1, 255, 1, 255);
    tab[6] = mkv(100,  50,  30, 1, 0, 0, 120, 0, 120, 0,  20, 0,  20);
    tab[7] = mkv(  1,   2,   3, 0, 1, 1,   2, 1,   3, 0,   6, 0,   6);

    in_valid = 1'b0; ctl_1 = 1'b0; ctl_2 = 1'b0;
    a = '0; b = '0; c = '0; out_ready = 1'b1;
    drive_tab = 1'b0; drive_lat = 1'b0; drive_exp = '0;
    begin_window();
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_out_valid", i, 32'(out_valid_w[i]), 0);
      chk("rst_out",       i, 32'(out_w[i]),       0);
      chk("rst_ovf",       i, 32'(ovf_w[i]),       0);
      chk("rst_in_ready",  i, 32'(in_ready_w[i]),  1);
    end
    @(negedge clk);
    reset = 1'b1;
    step();

    // Test 1: single beat, exact latency
    a = 8'd10; b = 8'd3; c = 8'd5; ctl_1 = 1'b1; ctl_2 = 1'b0;
    drive_tab = 1'b1; drive_exp = tab[0].exp; drive_lat = 1'b1;
    in_valid = 1'b1;
    step();
    chk("t1_accept", 0, 32'(last_acc), 1);
    in_valid = 1'b0;
    #1 chk("t1_valid_k", 0, 32'(out_valid_w[0]), 0);
    step();
    #1 chk("t1_valid_k1", 0, 32'(out_valid_w[0]), 0);
    step();
    #1 chk("t1_valid_k2", 0, 32'(out_valid_w[0]), 1);
    drain();

    // Table vectors streamed back to back
    for (int r = 0; r < 8; r++) begin
      a = tab[r].a; b = tab[r].b; c = tab[r].c;
      ctl_1 = tab[r].c1; ctl_2 = tab[r].c2;
      drive_exp = tab[r].exp;
      in_valid = 1'b1;
      step();
      chk("tab_accept", r, 32'(last_acc), 1);
    end
    drain();
    drive_tab = 1'b0;

    // Test 4: backpressure fill, hold, release
    drive_lat = 1'b0;
    b = '0; c = '0; ctl_1 = 1'b1; ctl_2 = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; na = 1;
    for (int k = 0; k < 6; k++) begin
      a = 8'(na);
      step();
      if (last_acc) na++;
    end
    #1;
    chk("bp_accepts", 0, na - 1, 3);
    chk("bp_in_ready", 0, 32'(in_ready_w[0]), 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_out", i, 32'(out_w[i]), 1);
      chk("bp_hold_valid", i, 32'(out_valid_w[i]), 1);
    end
    out_ready = 1'b1;
    #1 chk("bp_restart_ready", 0, 32'(in_ready_w[0]), 1);
    begin_window();
    for (int k = 0; k < 20 && na <= 6; k++) begin
      a = 8'(na);
      step();
      if (last_acc) na++;
    end
    drain();
    chk("bp_pop_cnt", 0, pop_cnt, 6);
    chk("bp_no_gaps", 0, last_pop - first_pop, 5);

    // Test 5: reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; na = 0;
    for (int k = 0; k < 10 && na < 3; k++) begin
      a = 8'(7 + na);
      step();
      if (last_acc) na++;
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_valid", i, 32'(out_valid_w[i]), 0);
      chk("mid_rst_out",   i, 32'(out_w[i]),       0);
      chk("mid_rst_ready", i, 32'(in_ready_w[i]),  1);
    end
    sb_q.delete();
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("post_rst_quiet", 0, 32'(out_valid_w[0]), 0);
      step();
    end

    // Test 6: full throughput with random operands
    begin_window();
    drive_lat = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      c = 8'($urandom_range(0, 255));
      ctl_1 = 1'($urandom_range(0, 1));
      ctl_2 = 1'($urandom_range(0, 1));
      step();
      chk("rand_accept", k, 32'(last_acc), 1);
    end
    drain();
    chk("rand_pop_cnt", 0, pop_cnt, 100);
    chk("rand_no_gaps", 0, last_pop - first_pop, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
